mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_responder                                                |
// | Description : Single-port memory slave with a valid/ready handshake and a  |
// |               programmable number of wait states. Each request is captured |
// |               in IDLE, waits WAIT_STATES cycles, and completes with a      |
// |               one-cycle registered ready_o pulse in RESP.                   |
// |               Optional feature macro: MEM_RESP_ADDR_CHECK_EN adds err_o,  |
// |               suppresses writes to addresses >= DEPTH and returns zero for |
// |               reads from them.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module mem_responder #(
  parameter int WIDTH       = `WIDTH,
  parameter int ADDR_WIDTH  = `ADDR_WIDTH,
  parameter int DEPTH       = 2 ** ADDR_WIDTH,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  ready_o
`ifdef MEM_RESP_ADDR_CHECK_EN
  ,
  output logic                  err_o
`endif
);

  // Index width into the array; DEPTH is expected to be a power of two >= 2.
  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The counter is loaded with WAIT_STATES-1 so that exactly WAIT_STATES
  // cycles are spent in WAIT (the zero-count cycle included).
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic [WIDTH-1:0]        rdata_q, rdata_d;

  logic [WIDTH-1:0]        mem [DEPTH];

  logic                    cmd_wr;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [WIDTH-1:0]        cmd_wdata;
  logic [IDX_W-1:0]        cmd_idx;
  logic                    cmd_oor;
  logic                    enter_resp;
  logic                    mem_we;

  // Effective command: live inputs when RESP is entered straight from IDLE
  // (WAIT_STATES = 0), the latched copy otherwise, so late input changes
  // never reach the array.
  always_comb begin
    cmd_wr    = wr_q;
    cmd_addr  = addr_q;
    cmd_wdata = wdata_q;
    if (state_q == IDLE) begin
      cmd_wr    = wr_rd_en_i;
      cmd_addr  = addr_i;
      cmd_wdata = wdata_i;
    end
    cmd_idx = cmd_addr[IDX_W-1:0];
`ifdef MEM_RESP_ADDR_CHECK_EN
    cmd_oor = (32'(cmd_addr) >= 32'(DEPTH));
`else
    cmd_oor = 1'b0;
`endif
  end

  // Next-state, capture and response-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          wr_d    = wr_rd_en_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Memory access and response registers update on the edge entering RESP.
    enter_resp = (state_d == RESP) && (state_q != RESP);
    ready_d    = enter_resp;
    rdata_d    = rdata_q;
    if (enter_resp && !cmd_wr) begin
      rdata_d = cmd_oor ? '0 : mem[cmd_idx];
    end
    mem_we = enter_resp && cmd_wr && !cmd_oor;
  end

  // Control and response registers; asynchronous reset aborts any transfer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array: never reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk_i) begin
    if (mem_we && rst_i) begin
      mem[cmd_idx] <= cmd_wdata;
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;

`ifdef MEM_RESP_ADDR_CHECK_EN
  logic err_q, err_d;

  // Error flag pulses alongside ready_o for out-of-range requests.
  always_comb begin
    err_d = enter_resp && cmd_oor;
  end

  // Error flag register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_responder                                             |
// | Description : Self-checking bench for mem_responder. Instance dut uses     |
// |               WAIT_STATES=2, DEPTH=16, ADDR_WIDTH=8; instance dut0 uses    |
// |               WAIT_STATES=0 with full-depth memory. Read data expectations |
// |               come from a reference model via a scoreboard queue.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_responder;

  localparam int WS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic       rst_n;
  logic       valid;
  logic       wr_rd;
  logic [7:0] addr_in;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ready;
  logic       err;

  // Zero-wait-state instance signals
  logic       rst0_n;
  logic       v0;
  logic       wr0;
  logic [7:0] a0;
  logic [7:0] d0;
  logic [7:0] rdata0;
  logic       rdy0;
  logic       err0;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [16];
  logic [7:0] m0 [4];
  logic [7:0] sb_q [$];
  logic [7:0] sb0_q [$];
  logic [7:0] last_rd;

  bit         b2b_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] b2b_addr [4] = '{8'h01, 8'h02, 8'h01, 8'h02};
  logic [7:0] b2b_data [4] = '{8'hC1, 8'hC2, 8'h00, 8'h00};

  mem_responder #(
    .WIDTH(8), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(WS)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .wr_rd_en_i(wr_rd),
    .addr_i(addr_in), .wdata_i(wdata), .rdata_o(rdata), .ready_o(ready)
`ifdef MEM_RESP_ADDR_CHECK_EN
    , .err_o(err)
`endif
  );

  mem_responder #(
    .WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst0_n), .valid_i(v0), .wr_rd_en_i(wr0),
    .addr_i(a0), .wdata_i(d0), .rdata_o(rdata0), .ready_o(rdy0)
`ifdef MEM_RESP_ADDR_CHECK_EN
    , .err_o(err0)
`endif
  );

`ifndef MEM_RESP_ADDR_CHECK_EN
  assign err  = 1'b0;
  assign err0 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer on dut. ready_o must stay low after the capture edge
  // and the following WS-1 edges, be high before edge capture+WS+1 (where the
  // initiator samples it), then drop.
  task automatic xact(input logic wr, input logic [7:0] a, input logic [7:0] d, input bit corrupt);
    logic [7:0] exp_rd;
    bit         oor;
    @(negedge clk);
    valid   = 1'b1;
    wr_rd   = wr;
    addr_in = a;
    wdata   = d;
    oor     = 1'b0;
`ifdef MEM_RESP_ADDR_CHECK_EN
    oor = (a >= 8'd16);
`endif
    if (!wr) sb_q.push_back(oor ? 8'h00 : model[a[3:0]]);
    else if (!oor) model[a[3:0]] = d;
    @(posedge clk);
    for (int k = 0; k < WS; k++) begin
      @(negedge clk);
      if (corrupt && k == 0) begin
        addr_in = 8'h0F;
        wdata   = 8'hFF;
      end
      check("ready_early", {31'd0, ready}, 32'd0);
      if (wr) check("rdata_hold_wait", {24'd0, rdata}, {24'd0, last_rd});
    end
    @(negedge clk);
    check("ready_pulse", {31'd0, ready}, 32'd1);
`ifdef MEM_RESP_ADDR_CHECK_EN
    check("err_pulse", {31'd0, err}, {31'd0, oor});
`endif
    if (!wr) begin
      if (sb_q.size() == 0) begin
        errors++;
        $error("FAIL sb_underflow: observed empty expected one entry");
      end else begin
        exp_rd = sb_q.pop_front();
        check("rdata", {24'd0, rdata}, {24'd0, exp_rd});
        last_rd = exp_rd;
      end
    end else begin
      check("rdata_hold_resp", {24'd0, rdata}, {24'd0, last_rd});
    end
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check("ready_drop", {31'd0, ready}, 32'd0);
    check("err_drop", {31'd0, err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] e;
    rst_n = 1'b0; rst0_n = 1'b0;
    valid = 1'b0; wr_rd = 1'b0; addr_in = 8'h00; wdata = 8'h00;
    v0 = 1'b0; wr0 = 1'b0; a0 = 8'h00; d0 = 8'h00;
    last_rd = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready0", {31'd0, rdy0}, 32'd0);
    check("rst_rdata0", {24'd0, rdata0}, 32'd0);
    rst_n = 1'b1; rst0_n = 1'b1;

    // Fill every location with a known pattern
    for (int i = 0; i < 16; i++) xact(1'b1, 8'(i), 8'(8'h30 + i), 1'b0);

    // Write then read back 0x05
    xact(1'b1, 8'h05, 8'hA5, 1'b0);
    xact(1'b0, 8'h05, 8'h00, 1'b0);

    // Inputs changed during WAIT must be ignored
    xact(1'b1, 8'h03, 8'h11, 1'b1);
    xact(1'b0, 8'h03, 8'h00, 1'b0);
    xact(1'b0, 8'h0F, 8'h00, 1'b0);

    // Out-of-range address: aliases to 0x00, or errors when checking is built in
    xact(1'b1, 8'h20, 8'h55, 1'b0);
    xact(1'b0, 8'h00, 8'h00, 1'b0);

    // Read data holds through a later write
    xact(1'b0, 8'h04, 8'h00, 1'b0);
    xact(1'b1, 8'h09, 8'h99, 1'b0);
    @(negedge clk);
    check("rdata_hold_idle", {24'd0, rdata}, {24'd0, last_rd});

    // Reset in WAIT of a write to 0x07 aborts it
    @(negedge clk);
    valid = 1'b1; wr_rd = 1'b1; addr_in = 8'h07; wdata = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_rdata", {24'd0, rdata}, 32'd0);
    valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_pulse", {31'd0, ready}, 32'd0);
    end
    rst_n = 1'b1;
    last_rd = 8'h00;
    xact(1'b0, 8'h07, 8'h00, 1'b0);
    xact(1'b0, 8'h09, 8'h00, 1'b0);

    // Zero wait states, valid held high across back-to-back transfers
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      v0 = 1'b1; wr0 = b2b_wr[i]; a0 = b2b_addr[i]; d0 = b2b_data[i];
      if (!b2b_wr[i]) sb0_q.push_back(m0[b2b_addr[i][1:0]]);
      else m0[b2b_addr[i][1:0]] = b2b_data[i];
      @(posedge clk);
      @(negedge clk);
      check("b2b_ready_hi", {31'd0, rdy0}, 32'd1);
      if (!b2b_wr[i]) begin
        if (sb0_q.size() == 0) begin
          errors++;
          $error("FAIL sb0_underflow: observed empty expected one entry");
        end else begin
          e = sb0_q.pop_front();
          check("b2b_rdata", {24'd0, rdata0}, {24'd0, e});
        end
      end
      @(negedge clk);
      check("b2b_ready_lo", {31'd0, rdy0}, 32'd0);
    end
    v0 = 1'b0;
    @(negedge clk);
    check("b2b_idle", {31'd0, rdy0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
